pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 19 +
 rtl/pipe_skid_reg.sv | 97 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and the
// default MEM/WB payload layout used by the wrapper that packs the bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } pipe_state_e;

    // MEM/WB bundle field widths, LSB first in the packed payload.
    localparam int MEMWB_RD_W     = 5;
    localparam int MEMWB_WB_SEL_W = 2;
    localparam int MEMWB_WORD_W   = 32;

    localparam int MEMWB_RD_LSB     = 0;
    localparam int MEMWB_WB_SEL_LSB = MEMWB_RD_LSB + MEMWB_RD_W;
    localparam int MEMWB_REG_WE_BIT = MEMWB_WB_SEL_LSB + MEMWB_WB_SEL_W;
    localparam int MEMWB_PC4_LSB    = MEMWB_REG_WE_BIT + 1;
    localparam int MEMWB_ALU_LSB    = MEMWB_PC4_LSB + MEMWB_WORD_W;
    localparam int MEMWB_IMM_LSB    = MEMWB_ALU_LSB + MEMWB_WORD_W;
    localparam int MEMWB_DMEM_LSB   = MEMWB_IMM_LSB + MEMWB_WORD_W;
    localparam int MEMWB_W          = MEMWB_DMEM_LSB + MEMWB_WORD_W;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts INC cycles and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            COUNT <= '0;
        end else if (INC && (COUNT != {CNT_W{1'b1}})) begin
            COUNT <= COUNT + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a pipeline stage: main register feeds OUT_DATA,
// skid register absorbs one extra entry so IN_READY depends on state only.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               DATA_W   = MEMWB_W,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter int               CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              BUSYWAIT,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CNT_W-1:0]  STALL_CNT,
    output pipe_state_e       STATE_DBG
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; BUSYWAIT masks OUT_READY, and IN_READY is a pure decode
    // of registered state so it never depends on OUT_READY or BUSYWAIT.
    pipe_state_e       state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              take_in;
    logic              take_out;

    assign take_in  = IN_VALID & in_ready_q;
    assign take_out = out_valid_q & OUT_READY & ~BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (!RESET || FLUSH) begin
            state_q     <= ST_EMPTY;
            main_q      <= RST_DATA;
            skid_q      <= RST_DATA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (take_in) begin
                        state_q     <= ST_FULL;
                        main_q      <= IN_DATA;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (take_in && take_out) begin
                        main_q <= IN_DATA;
                    end else if (take_in) begin
                        state_q    <= ST_SKID;
                        skid_q     <= IN_DATA;
                        in_ready_q <= 1'b0;
                    end else if (take_out) begin
                        // main_q keeps the delivered value after draining
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (take_out) begin
                        state_q    <= ST_FULL;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = main_q;
    assign STATE_DBG = state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (out_valid_q & ~take_out),
        .COUNT (STALL_CNT)
    );

endmodule
